// File: rtl/game_tick_gen_if.sv
// Control and tick bundle for the game tick generator.
// master: the game controller driving the generator; slave: the generator.
interface game_tick_gen_if #(
    parameter int CNT_W   = 11,
    parameter int NUM_CH  = 3,
    parameter int LEVEL_W = 3
);
    logic               pause;
    logic               period_load;
    logic [CNT_W-1:0]   period_in;
    logic               level_up;
    logic               level_clr;
    logic [NUM_CH-1:0]  tick;
    logic [LEVEL_W-1:0] level;
    logic               level_max;

    modport master (
        output pause, period_load, period_in, level_up, level_clr,
        input  tick, level, level_max
    );

    modport slave (
        input  pause, period_load, period_in, level_up, level_clr,
        output tick, level, level_max
    );
endinterface

// File: rtl/game_tick_gen.sv
// Programmable multi-channel game-rate tick generator.
// One base down-counter reloads to eff = max(R >> level, MIN_RELOAD) and fires a
// base event every eff+1 cycles; a free-running prescaler divides that event into
// binary-ratio channels (ch k fires on every 2**k-th base event).
module game_tick_gen #(
    parameter int CNT_W      = 11,
    parameter int NUM_CH     = 3,
    parameter int LEVEL_W    = 3,
    parameter int DEF_RELOAD = 2**CNT_W - 1,
    parameter int MIN_RELOAD = 63
) (
    input  logic           clk,
    input  logic           reset,
    game_tick_gen_if.slave bus
);
    localparam int               PRE_W = (NUM_CH > 1) ? NUM_CH - 1 : 1;
    localparam logic [CNT_W-1:0] MIN_R = CNT_W'(MIN_RELOAD);
    localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_RELOAD);

    logic [CNT_W-1:0]   reload;
    logic [CNT_W-1:0]   cnt;
    logic [LEVEL_W-1:0] level;
    logic [NUM_CH-1:0]  tick;
    logic [NUM_CH-1:0]  tick_nxt;
    logic [CNT_W-1:0]   eff;
    logic [CNT_W-1:0]   load_r;
    logic [CNT_W-1:0]   load_eff;
    logic               base_evt;

    function automatic logic [CNT_W-1:0] clamp_eff(input logic [CNT_W-1:0] rv,
                                                   input logic [LEVEL_W-1:0] lv);
        logic [CNT_W-1:0] sh;
        sh = rv >> lv;
        return (sh < MIN_R) ? MIN_R : sh;
    endfunction

    // Effective interval for the current R and for a reload value being latched.
    // A load uses the level held before this edge, even if the level also changes.
    always_comb begin
        eff      = clamp_eff(reload, level);
        load_r   = (bus.period_in < MIN_R) ? MIN_R : bus.period_in;
        load_eff = clamp_eff(load_r, level);
        base_evt = !bus.period_load && !bus.pause && (cnt == '0);
    end

    // Base interval counter and reload register: load > pause > count.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload <= DEF_R;
            cnt    <= '0;
        end else if (bus.period_load) begin
            reload <= load_r;
            cnt    <= load_eff;
        end else if (!bus.pause) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else           cnt <= eff;
        end
    end

    // Prescaler and per-channel tick decode; absent for a single channel.
    generate
        if (NUM_CH > 1) begin : g_pre
            logic [PRE_W-1:0]  pre;
            logic [NUM_CH-2:0] tick_hi;

            // Prescaler advances once per base event and restarts on a load.
            always_ff @(posedge clk) begin
                if (reset)                pre <= '0;
                else if (bus.period_load) pre <= '0;
                else if (base_evt)        pre <= pre + 1'b1;
            end

            // Channel k fires when the low k prescaler bits are all zero.
            always_comb begin
                tick_hi = '0;
                for (int k = 1; k < NUM_CH; k++)
                    tick_hi[k-1] = base_evt && ((pre & PRE_W'((1 << k) - 1)) == '0);
            end

            assign tick_nxt = {tick_hi, base_evt};
        end else begin : g_nopre
            assign tick_nxt = base_evt;
        end
    endgenerate

    // Registered one-cycle tick pulses.
    always_ff @(posedge clk) begin
        if (reset) tick <= '0;
        else       tick <= tick_nxt;
    end

    // Difficulty level: clear wins over up, up saturates at the top level.
    always_ff @(posedge clk) begin
        if (reset)                               level <= '0;
        else if (bus.level_clr)                  level <= '0;
        else if (bus.level_up && (level != '1))  level <= level + 1'b1;
    end

    assign bus.tick      = tick;
    assign bus.level     = level;
    assign bus.level_max = (level == '1);
endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen: the stimulus pushes hand-computed tick events
// (edge number, tick vector) into a queue; a monitor compares every cycle.
module tb_game_tick_gen;
    localparam int CNT_W   = 4;
    localparam int NUM_CH  = 3;
    localparam int LEVEL_W = 2;

    typedef struct {
        int         e;
        logic [2:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    game_tick_gen_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W)) bus ();

    game_tick_gen #(
        .CNT_W(CNT_W), .NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W),
        .DEF_RELOAD(15), .MIN_RELOAD(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int e, input logic [2:0] t);
        exp_t x;
        x.e = e;
        x.t = t;
        q.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic run_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // Monitor: compares tick at each negedge against the expected-event queue.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            while (q.size() > 0 && q[0].e < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL tick_missed edge %0d expected %b", q[0].e, q[0].t);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].e == cyc) begin
                exp_t x;
                x = q.pop_front();
                n_vec++;
                if (bus.tick !== x.t) begin
                    n_err++;
                    $display("FAIL tick at edge %0d: got %b expected %b", cyc, bus.tick, x.t);
                end
            end else if (bus.tick !== 3'b000) begin
                n_vec++;
                n_err++;
                $display("FAIL tick_unexpected at edge %0d: got %b expected 000", cyc, bus.tick);
            end
        end
    end

    initial begin
        bus.pause       = 1'b0;
        bus.period_load = 1'b0;
        bus.period_in   = '0;
        bus.level_up    = 1'b0;
        bus.level_clr   = 1'b0;

        // 1: reset then free run at R=15
        run_to(1);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_level_max", int'(bus.level_max), 0);
        reset = 1'b0;
        push(2, 3'b111); push(18, 3'b001); push(34, 3'b011);
        push(50, 3'b001); push(66, 3'b111);
        run_to(70);
        chk("run_level", int'(bus.level), 0);

        // 2: pause for 10 edges mid-interval, tick0 shifts 10 late
        bus.pause = 1'b1;
        run_to(80);
        bus.pause = 1'b0;
        push(92, 3'b001); push(108, 3'b011);
        run_to(112);

        // 3: load period 5, then period 0 (clamped to 2)
        bus.period_load = 1'b1; bus.period_in = 4'd5;
        run_to(113);
        bus.period_load = 1'b0;
        push(119, 3'b111); push(125, 3'b001); push(131, 3'b011);
        push(137, 3'b001); push(143, 3'b111);
        run_to(144);
        bus.period_load = 1'b1; bus.period_in = 4'd0;
        run_to(145);
        bus.period_load = 1'b0;
        push(148, 3'b111); push(151, 3'b001); push(154, 3'b011);
        run_to(155);

        // 4: R=15 and four level_up pulses
        bus.period_load = 1'b1; bus.period_in = 4'd15;
        run_to(156);
        bus.period_load = 1'b0;
        bus.level_up = 1'b1;
        run_to(157);
        bus.level_up = 1'b0;
        chk("lvl1", int'(bus.level), 1);
        chk("lvl1_max", int'(bus.level_max), 0);
        push(172, 3'b111); push(180, 3'b001); push(184, 3'b011);
        push(187, 3'b001); push(190, 3'b111); push(193, 3'b001);
        run_to(173);
        bus.level_up = 1'b1;
        run_to(174);
        bus.level_up = 1'b0;
        chk("lvl2", int'(bus.level), 2);
        run_to(181);
        bus.level_up = 1'b1;
        run_to(182);
        bus.level_up = 1'b0;
        chk("lvl3", int'(bus.level), 3);
        chk("lvl3_max", int'(bus.level_max), 1);
        run_to(185);
        bus.level_up = 1'b1;
        run_to(186);
        bus.level_up = 1'b0;
        chk("lvl_sat", int'(bus.level), 3);
        chk("lvl_sat_max", int'(bus.level_max), 1);
        run_to(195);

        // 5: load on the cnt==0 edge with level_up+level_clr together
        bus.period_load = 1'b1; bus.period_in = 4'd5;
        bus.level_up = 1'b1; bus.level_clr = 1'b1;
        run_to(196);
        bus.period_load = 1'b0; bus.level_up = 1'b0; bus.level_clr = 1'b0;
        chk("clr_wins", int'(bus.level), 0);
        chk("clr_max", int'(bus.level_max), 0);
        push(199, 3'b111); push(205, 3'b001);
        run_to(207);

        // 6: reset mid-interval at level 2
        bus.level_up = 1'b1;
        run_to(209);
        bus.level_up = 1'b0;
        chk("pre_rst_level", int'(bus.level), 2);
        reset = 1'b1;
        run_to(210);
        chk("mid_rst_tick", int'(bus.tick), 0);
        chk("mid_rst_level", int'(bus.level), 0);
        chk("mid_rst_max", int'(bus.level_max), 0);
        reset = 1'b0;
        push(211, 3'b111); push(227, 3'b001);
        run_to(228);

        chk("events_left", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
